energy_meter_ctrl: RTL and testbench
====================================

Name: energy_meter_ctrl

Overview:
- Sequencing and protection controller around the V×I power datapath.
- Samples voltage/current on a programmable tick, computes power and accumulates energy.
- Debounces overload over consecutive samples, then opens the load relay.
- Recloses after a holdoff; after repeated trips it latches a lockout that only an explicit clear releases.

Parameters:
SAMPLE_DIV, 100, clock cycles between samples (≥2)
TRIP_COUNT, 3, consecutive over-threshold samples needed to trip (≥1)
HOLDOFF, 1000, cycles relay stays open after a trip before reclose (≥1)
MAX_TRIPS, 3, trips (without intervening IDLE/clear) that force lockout (≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  level; 1 = meter/relay operation requested
voltage  input  8  unsigned voltage sample
current  input  8  unsigned current sample
threshold  input  16  unsigned power limit, compared strictly (power > threshold)
clear_lockout  input  1  single-cycle pulse, releases LOCKOUT
power  output  16  last sampled V×I, registered
energy  output  32  saturating sum of sampled power
sample_valid  output  1  1-cycle pulse when power/energy update
over_load  output  1  last sample exceeded threshold
relay_on  output  1  load relay closed
protection  output  1  1 in TRIP or LOCKOUT
lockout  output  1  1 in LOCKOUT
trip_count  output  8  trips since last IDLE/clear

Behaviour:
- Reset (async, active-high): state=IDLE; power=0, energy=0, sample_valid=0, over_load=0, relay_on=0, protection=0, lockout=0, trip_count=0. All internal counters=0.
- States: IDLE, RUN, TRIP, LOCKOUT. Outputs relay_on/protection/lockout are registered decodes of the state.
  - relay_on=1 only in RUN.
  - protection=1 in TRIP and LOCKOUT.
  - lockout=1 only in LOCKOUT.
- IDLE:
  - enable=1 → RUN next cycle.
  - trip_count, the consecutive-over counter and the tick counter are all held at 0.
- RUN:
  - Tick counter counts 0..SAMPLE_DIV-1 and restarts at 0 on every RUN entry. The first sample occurs SAMPLE_DIV cycles after entry.
  - On a sample cycle:
    - power ← voltage×current (full 16-bit product, max 65025, no truncation).
    - energy ← energy+product, saturating at 0xFFFFFFFF.
    - over_load ← (product > threshold).
    - sample_valid=1 for exactly that cycle; power, energy and over_load all update on the same edge.
  - Consecutive-over counter: increments on an over sample, clears on a non-over sample.
  - When the counter reaches TRIP_COUNT:
    - trip_count increments, saturating at 255.
    - If the new trip_count ≥ MAX_TRIPS → LOCKOUT, else → TRIP.
    - The consecutive-over counter clears.
  - enable=0 → IDLE next cycle. A sample scheduled on that same cycle is still taken.
- TRIP:
  - Holdoff counter counts HOLDOFF cycles, then → RUN (reclose).
  - No sampling; power, energy and over_load hold their values.
  - enable=0 → IDLE immediately (overrides holdoff).
- LOCKOUT:
  - Ignores enable.
  - clear_lockout=1 → IDLE and trip_count=0.
  - No sampling.
- Leaving to IDLE from any state clears trip_count.
- clear_lockout outside LOCKOUT is ignored.
- energy and power persist across IDLE/TRIP/LOCKOUT; only reset clears them.
- Simultaneous events:
  - A trip condition and enable=0 on the same RUN cycle → IDLE. trip_count is still cleared (IDLE wins).
  - A threshold change takes effect at the next sample only.
- Reset mid-operation: relay_on drops asynchronously with reset assertion. First RUN after release requires enable and a full SAMPLE_DIV wait.

Test Plan:
- Params SAMPLE_DIV=4, TRIP_COUNT=3, HOLDOFF=10, MAX_TRIPS=2. V=10, I=20, threshold=1000, enable=1 → relay_on 1 cycle after enable; sample_valid every 4 cycles; power=200; energy=200,400,600…; over_load=0.
- V=50, I=30 (1500), threshold=1000 → over_load=1 on the 1st sample; relay_on=0 and protection=1 after the 3rd sample; trip_count=1; reclose after 10 cycles.
- Over, over, under, over, over pattern (threshold=1000, power 1500/500) → no trip; counter resets on the under sample.
- Sustained 1500 → second trip gives LOCKOUT (lockout=1, trip_count=2). Toggling enable has no effect; a clear_lockout pulse → IDLE, trip_count=0, then RUN if enable=1.
- power=power threshold exactly (V=25, I=40, threshold=1000) → over_load=0 (strict compare). V=I=255 with energy preloaded near 0xFFFFFFFF → energy saturates at 0xFFFFFFFF.
- Assert reset during TRIP holdoff → all outputs 0 immediately; after release with enable=1, first sample_valid exactly 4 cycles after RUN entry.

Source files
------------

// File: rtl/energy_meter_ctrl.sv
// Energy meter sequencing and protection controller: samples V x I on a tick,
// accumulates saturating energy, trips the load relay on sustained overload.
module energy_meter_ctrl #(
  parameter int unsigned SAMPLE_DIV = 100,
  parameter int unsigned TRIP_COUNT = 3,
  parameter int unsigned HOLDOFF    = 1000,
  parameter int unsigned MAX_TRIPS  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  voltage,
  input  logic [7:0]  current,
  input  logic [15:0] threshold,
  input  logic        clear_lockout,
  output logic [15:0] power,
  output logic [31:0] energy,
  output logic        sample_valid,
  output logic        over_load,
  output logic        relay_on,
  output logic        protection,
  output logic        lockout,
  output logic [7:0]  trip_count
);

  localparam int unsigned TickW = $clog2(SAMPLE_DIV);
  localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned OverW = $clog2(TRIP_COUNT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StTrip, StLockout} state_e;

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_q;
  logic [HoldW-1:0] hold_q;
  logic [OverW-1:0] over_cnt_q;
  logic [OverW-1:0] over_cnt_inc;
  logic [31:0]      energy_q;
  logic [31:0]      energy_sat;
  logic [32:0]      energy_sum;
  logic [15:0]      product;
  logic [7:0]       trip_cnt_inc;
  logic             sample_hit;
  logic             is_over;
  logic             trip_hit;
  logic             trip_locks;

  assign energy = energy_q;

  always_comb begin
    product      = {8'd0, voltage} * {8'd0, current};
    energy_sum   = {1'b0, energy_q} + {17'd0, product};
    energy_sat   = energy_sum[32] ? 32'hFFFF_FFFF : energy_sum[31:0];
    sample_hit   = (state_q == StRun) && (tick_q == TickW'(SAMPLE_DIV - 1));
    is_over      = product > threshold;
    over_cnt_inc = over_cnt_q + OverW'(1);
    trip_hit     = sample_hit && is_over && (over_cnt_inc == OverW'(TRIP_COUNT));
    trip_cnt_inc = (trip_count == 8'hFF) ? 8'hFF : trip_count + 8'd1;
    trip_locks   = 32'(trip_cnt_inc) >= MAX_TRIPS;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        // Dropping enable wins over a simultaneous trip.
        if (!enable)       state_d = StIdle;
        else if (trip_hit) state_d = trip_locks ? StLockout : StTrip;
      end
      StTrip: begin
        if (!enable)                              state_d = StIdle;
        else if (hold_q == HoldW'(HOLDOFF - 1))   state_d = StRun;
      end
      StLockout: begin
        if (clear_lockout) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      hold_q       <= '0;
      over_cnt_q   <= '0;
      energy_q     <= '0;
      power        <= '0;
      sample_valid <= 1'b0;
      over_load    <= 1'b0;
      relay_on     <= 1'b0;
      protection   <= 1'b0;
      lockout      <= 1'b0;
      trip_count   <= '0;
    end else begin
      state_q      <= state_d;
      relay_on     <= (state_d == StRun);
      protection   <= (state_d == StTrip) || (state_d == StLockout);
      lockout      <= (state_d == StLockout);
      sample_valid <= sample_hit;

      // A sample due on the cycle enable drops is still taken.
      if (sample_hit) begin
        power     <= product;
        energy_q  <= energy_sat;
        over_load <= is_over;
      end

      if (state_q == StRun && state_d == StRun) begin
        tick_q <= sample_hit ? '0 : tick_q + TickW'(1);
      end else begin
        tick_q <= '0;
      end

      if (state_q == StTrip && state_d == StTrip) begin
        hold_q <= hold_q + HoldW'(1);
      end else begin
        hold_q <= '0;
      end

      if (state_q != StRun || state_d != StRun) begin
        over_cnt_q <= '0;
      end else if (sample_hit) begin
        over_cnt_q <= is_over ? over_cnt_inc : '0;
      end

      if (state_d == StIdle) begin
        trip_count <= '0;
      end else if (trip_hit) begin
        trip_count <= trip_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_energy_meter_ctrl.sv
// Directed bench for energy_meter_ctrl with small parameters and hand-computed results.
module tb_energy_meter_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  voltage;
  logic [7:0]  current;
  logic [15:0] threshold;
  logic        clear_lockout;
  logic [15:0] power;
  logic [31:0] energy;
  logic        sample_valid;
  logic        over_load;
  logic        relay_on;
  logic        protection;
  logic        lockout;
  logic [7:0]  trip_count;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  logic [31:0] exp_e;
  int          n;

  always #5 clk = ~clk;

  energy_meter_ctrl #(
    .SAMPLE_DIV(4),
    .TRIP_COUNT(3),
    .HOLDOFF   (10),
    .MAX_TRIPS (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .voltage      (voltage),
    .current      (current),
    .threshold    (threshold),
    .clear_lockout(clear_lockout),
    .power        (power),
    .energy       (energy),
    .sample_valid (sample_valid),
    .over_load    (over_load),
    .relay_on     (relay_on),
    .protection   (protection),
    .lockout      (lockout),
    .trip_count   (trip_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Bounded wait for the next sample pulse; returns negedges elapsed.
  task automatic wait_sv(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sample_valid && cnt < 40);
    if (!sample_valid) check_eq("sample_timeout", 32'(cnt), 32'd0);
  endtask

  task automatic wait_relay(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!relay_on && cnt < 40);
    if (!relay_on) check_eq("relay_timeout", 32'(cnt), 32'd0);
  endtask

  task automatic add_energy(input logic [15:0] p);
    logic [32:0] s;
    s = {1'b0, exp_e} + {17'd0, p};
    exp_e = s[32] ? 32'hFFFF_FFFF : s[31:0];
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; voltage = 8'd10; current = 8'd20;
    threshold = 16'd1000; clear_lockout = 1'b0; exp_e = 0;
    step(2);
    check_eq("rst_power", {16'd0, power}, 32'd0);
    check_eq("rst_energy", energy, 32'd0);
    check_eq("rst_flags", {26'd0, sample_valid, over_load, relay_on, protection, lockout, 1'b0},
             32'd0);
    check_eq("rst_trips", {24'd0, trip_count}, 32'd0);
    reset = 1'b0;
    step(1);

    // Normal metering at 200 W
    enable = 1'b1;
    step(1);
    check_eq("run_relay", {31'd0, relay_on}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      wait_sv(n);
      add_energy(16'd200);
      check_eq("run_period", 32'(n), (k == 0) ? 32'd4 : 32'd3);
      check_eq("run_power", {16'd0, power}, 32'd200);
      check_eq("run_energy", energy, exp_e);
      check_eq("run_over", {31'd0, over_load}, 32'd0);
      step(1);
      check_eq("sv_pulse", {31'd0, sample_valid}, 32'd0);
    end

    // 1500 W overload: three samples trip
    voltage = 8'd50; current = 8'd30;
    for (int k = 0; k < 3; k++) begin
      wait_sv(n);
      add_energy(16'd1500);
      check_eq("ovl_over", {31'd0, over_load}, 32'd1);
      check_eq("ovl_energy", energy, exp_e);
      check_eq("ovl_relay", {31'd0, relay_on}, (k < 2) ? 32'd1 : 32'd0);
    end
    check_eq("trip_prot", {31'd0, protection}, 32'd1);
    check_eq("trip_cnt1", {24'd0, trip_count}, 32'd1);
    wait_relay(n);
    check_eq("holdoff", 32'(n), 32'd10);
    check_eq("reclose_prot", {31'd0, protection}, 32'd0);

    // over, over, under, over, over: no trip
    for (int k = 0; k < 5; k++) begin
      current = (k == 2) ? 8'd10 : 8'd30;
      wait_sv(n);
      if (k == 0) check_eq("reclose_first", 32'(n), 32'd4);
      add_energy((k == 2) ? 16'd500 : 16'd1500);
      check_eq("pat_over", {31'd0, over_load}, (k == 2) ? 32'd0 : 32'd1);
      check_eq("pat_energy", energy, exp_e);
      check_eq("pat_relay", {31'd0, relay_on}, 32'd1);
    end

    // Third consecutive over: second trip locks out
    wait_sv(n);
    add_energy(16'd1500);
    check_eq("lock_flag", {31'd0, lockout}, 32'd1);
    check_eq("lock_prot", {31'd0, protection}, 32'd1);
    check_eq("lock_relay", {31'd0, relay_on}, 32'd0);
    check_eq("lock_trips", {24'd0, trip_count}, 32'd2);
    enable = 1'b0;
    step(3);
    check_eq("lock_hold_en0", {31'd0, lockout}, 32'd1);
    enable = 1'b1;
    step(3);
    check_eq("lock_hold_en1", {31'd0, lockout}, 32'd1);
    check_eq("lock_no_sample", energy, exp_e);
    clear_lockout = 1'b1;
    step(1);
    clear_lockout = 1'b0;
    check_eq("clr_lock", {31'd0, lockout}, 32'd0);
    check_eq("clr_prot", {31'd0, protection}, 32'd0);
    check_eq("clr_relay", {31'd0, relay_on}, 32'd0);
    check_eq("clr_trips", {24'd0, trip_count}, 32'd0);
    check_eq("clr_power", {16'd0, power}, 32'd1500);
    step(1);
    check_eq("clr_rerun", {31'd0, relay_on}, 32'd1);

    // Product equal to threshold is not an overload
    voltage = 8'd25; current = 8'd40;
    wait_sv(n);
    add_energy(16'd1000);
    check_eq("eq_period", 32'(n), 32'd4);
    check_eq("eq_power", {16'd0, power}, 32'd1000);
    check_eq("eq_over", {31'd0, over_load}, 32'd0);
    check_eq("eq_energy", energy, exp_e);

    // Trip, then reset during holdoff
    voltage = 8'd50; current = 8'd30;
    repeat (3) wait_sv(n);
    check_eq("t6_prot", {31'd0, protection}, 32'd1);
    check_eq("t6_trips", {24'd0, trip_count}, 32'd1);
    step(3);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_prot", {31'd0, protection}, 32'd0);
    check_eq("arst_trips", {24'd0, trip_count}, 32'd0);
    check_eq("arst_energy", energy, 32'd0);
    check_eq("arst_power", {16'd0, power}, 32'd0);
    exp_e = 0;
    @(negedge clk);
    reset = 1'b0;
    step(1);
    check_eq("post_rst_relay", {31'd0, relay_on}, 32'd1);
    wait_sv(n);
    add_energy(16'd1500);
    check_eq("post_rst_period", 32'(n), 32'd4);
    check_eq("post_rst_energy", energy, exp_e);

    // Trip condition and enable drop on the same sample: IDLE wins
    wait_sv(n);
    add_energy(16'd1500);
    step(3);
    enable = 1'b0;
    step(1);
    add_energy(16'd1500);
    check_eq("sim_sv", {31'd0, sample_valid}, 32'd1);
    check_eq("sim_energy", energy, exp_e);
    check_eq("sim_prot", {31'd0, protection}, 32'd0);
    check_eq("sim_relay", {31'd0, relay_on}, 32'd0);
    check_eq("sim_trips", {24'd0, trip_count}, 32'd0);

    // Energy saturation with a preloaded accumulator
    step(1);
    dut.energy_q = 32'hFFFE_795F;
    exp_e = 32'hFFFE_795F;
    voltage = 8'd255; current = 8'd255; threshold = 16'hFFFF; enable = 1'b1;
    step(1);
    for (int k = 0; k < 3; k++) begin
      wait_sv(n);
      add_energy(16'd65025);
      check_eq("sat_power", {16'd0, power}, 32'd65025);
      check_eq("sat_energy", energy, (k == 0) ? 32'hFFFF_7760 : 32'hFFFF_FFFF);
      check_eq("sat_model", energy, exp_e);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
